itch_add_rx_parser: RTL

Receive-side decoder for the feed handler's ITCH "Add Order" stream. It consumes the byte-wide AXI-Stream payload delivered after UDP/IP header stripping and extracts the 15-byte 'A' message into parallel fields. It presents each decoded message on a valid/ready output for the book builder. It is the inverse of the transmit-side payload generator and uses the same message layout.

---
 rtl/itch_pkg.sv | 24 ++
 rtl/itch_add_rx_parser.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/itch_pkg.sv
// itch_pkg: constants shared by the ITCH "Add Order" transmit generator and
// the receive parser. It holds the message type byte, the frame length, the
// field byte offsets and the receive parser state encoding.
package itch_pkg;

  localparam logic [7:0] ITCH_TYPE_ADD = 8'h41;
  localparam int         ITCH_ADD_LEN  = 15;

  // Byte offsets of each field within the frame. Byte 0 is the type byte.
  localparam int OID_OFS   = 1;
  localparam int QTY_OFS   = 9;
  localparam int PRICE_OFS = 11;

  // Index of the final byte of a well-formed frame.
  localparam logic [3:0] ITCH_LAST_IDX = 4'(ITCH_ADD_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } itch_rx_state_t;

endpackage

// File: rtl/itch_add_rx_parser.sv
// itch_add_rx_parser: receive-side decoder for the ITCH "Add Order" stream.
// It takes the byte-wide payload after UDP/IP stripping, checks the type byte
// and the exact 15-byte length, and presents order_id/qty/price on a
// valid/ready output. Malformed frames are dropped and counted.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   s_tvalid/s_tready/s_tdata/s_tlast   byte-wide AXI-Stream payload input
//   m_valid/m_ready decoded-message handshake
//   m_order_id      bytes 1-8, big-endian
//   m_qty           bytes 9-10, big-endian
//   m_price         bytes 11-14, big-endian
//   sof_pulse       one-cycle pulse after byte 0 of any frame is accepted
//   msg_count       good messages emitted (saturating)
//   err_count       rejected frames (saturating)
module itch_add_rx_parser
  import itch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [7:0]       s_tdata,
  input  logic             s_tlast,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_order_id,
  output logic [15:0]      m_qty,
  output logic [31:0]      m_price,
  output logic             sof_pulse,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] err_count
);

  // Body bytes (1..14) and the shift register holding bytes 1..13 while the
  // final byte is still in flight.
  localparam int BODY_BYTES = ITCH_ADD_LEN - 1;
  localparam int MSG_W      = 8 * BODY_BYTES;
  localparam int SR_W       = MSG_W - 8;

  // Bit positions of each field inside the assembled body, MSB first.
  localparam int OID_LSB   = (ITCH_ADD_LEN - OID_OFS   - 8) * 8;
  localparam int QTY_LSB   = (ITCH_ADD_LEN - QTY_OFS   - 2) * 8;
  localparam int PRICE_LSB = (ITCH_ADD_LEN - PRICE_OFS - 4) * 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  itch_rx_state_t   state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic             accept;
  logic             sof_evt;
  logic             err_evt;
  logic             msg_evt;
  logic             clr_valid;
  logic [SR_W-1:0]  body_sr;
  logic [MSG_W-1:0] msg_full;

  // Upstream only ever stalls on an unconsumed output message.
  assign s_tready = (state != ST_HOLD);
  assign accept   = s_tvalid && s_tready;
  assign msg_full = {body_sr, s_tdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sof_evt   = 1'b0;
    err_evt   = 1'b0;
    msg_evt   = 1'b0;
    clr_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          sof_evt = 1'b1;
          if (s_tlast) begin
            err_evt = 1'b1;
          end else if (s_tdata == ITCH_TYPE_ADD) begin
            state_nxt = ST_BODY;
            idx_nxt   = 4'd1;
          end else begin
            state_nxt = ST_DROP;
            err_evt   = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (accept) begin
          if (idx == ITCH_LAST_IDX) begin
            if (s_tlast) begin
              msg_evt   = 1'b1;
              state_nxt = ST_HOLD;
            end else begin
              err_evt   = 1'b1;
              state_nxt = ST_DROP;
            end
          end else if (s_tlast) begin
            err_evt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_tlast) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          clr_valid = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt == ST_IDLE) begin
      idx_nxt = 4'd0;
    end
  end

  // Body capture: no reset needed, contents are only used once the full
  // frame has been seen since the last reset.
  always_ff @(posedge clk) begin
    if (accept && state == ST_BODY) begin
      body_sr <= {body_sr[SR_W-9:0], s_tdata};
    end
  end

  // Output registers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_order_id <= '0;
      m_qty      <= '0;
      m_price    <= '0;
      sof_pulse  <= 1'b0;
      msg_count  <= '0;
      err_count  <= '0;
    end else begin
      sof_pulse <= sof_evt;
      if (msg_evt) begin
        m_valid    <= 1'b1;
        m_order_id <= msg_full[OID_LSB +: 64];
        m_qty      <= msg_full[QTY_LSB +: 16];
        m_price    <= msg_full[PRICE_LSB +: 32];
        msg_count  <= sat_inc(msg_count);
      end else if (clr_valid) begin
        m_valid <= 1'b0;
      end
      if (err_evt) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule
